// File: rtl/fifo_buffer_if.sv
// rtl/fifo_buffer_if.sv - bus-side handshake bundle for the SSP word FIFO
interface fifo_buffer_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             rw;
  logic [WIDTH-1:0] wordIn;
  logic [WIDTH-1:0] wordOut;
  logic             intr;

  modport master (
    output en,
    output rw,
    output wordIn,
    input  wordOut,
    input  intr
  );

  modport slave (
    input  en,
    input  rw,
    input  wordIn,
    output wordOut,
    output intr
  );
endinterface

// File: rtl/fifo_buffer.sv
// rtl/fifo_buffer.sv - synchronous word FIFO between parallel bus and SSP shift logic
module fifo_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                pclk,
  input  logic                clear,
  fifo_buffer_if.slave        bus
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_cnt;
  logic [WIDTH-1:0] r_word_out;

  logic w_full;
  logic w_empty;
  logic w_do_write;
  logic w_do_read;

  assign w_full     = (r_cnt == FULL_CNT);
  assign w_empty    = (r_cnt == '0);
  // A single rw strobe makes read and write mutually exclusive per edge.
  assign w_do_write = bus.en &  bus.rw & ~w_full;
  assign w_do_read  = bus.en & ~bus.rw & ~w_empty;

  always_ff @(posedge pclk) begin
    if (clear) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_cnt      <= '0;
      r_word_out <= '0;
    end else if (w_do_write) begin
      r_wp  <= r_wp + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(1);
    end else if (w_do_read) begin
      r_word_out <= r_mem[r_rp];
      r_rp       <= r_rp + AW'(1);
      r_cnt      <= r_cnt - (AW+1)'(1);
    end
  end

  // Storage is not flushed by clear; stale words are unreachable once pointers reset.
  always_ff @(posedge pclk) begin
    if (!clear && w_do_write) begin
      r_mem[r_wp] <= bus.wordIn;
    end
  end

  assign bus.wordOut = r_word_out;
  assign bus.intr    = w_full;

endmodule

// File: tb/tb_fifo_buffer.sv
// tb/tb_fifo_buffer.sv - directed self-checking bench for fifo_buffer
module tb_fifo_buffer;

  logic pclk;
  logic clear;
  int   n_checks;
  int   n_fail;

  fifo_buffer_if #(.WIDTH(8)) bus ();

  fifo_buffer #(.WIDTH(8), .DEPTH(4)) dut (
    .pclk  (pclk),
    .clear (clear),
    .bus   (bus.slave)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic c, input logic e, input logic r, input logic [7:0] d);
    clear      = c;
    bus.en     = e;
    bus.rw     = r;
    bus.wordIn = d;
    @(posedge pclk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    step(1'b0, 1'b1, 1'b1, d);
  endtask

  task automatic rd();
    step(1'b0, 1'b1, 1'b0, 8'h00);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    clear      = 1'b0;
    bus.en     = 1'b0;
    bus.rw     = 1'b0;
    bus.wordIn = 8'h00;
    #2;

    step(1'b1, 1'b0, 1'b0, 8'h00);
    check("reset_wordOut", bus.wordOut, 8'h00);
    check("reset_intr", {7'd0, bus.intr}, 8'h00);
    rd();
    check("empty_read_wordOut", bus.wordOut, 8'h00);
    check("empty_read_intr", {7'd0, bus.intr}, 8'h00);

    wr(8'h63); wr(8'h61); wr(8'h74);
    check("three_words_intr", {7'd0, bus.intr}, 8'h00);
    wr(8'h73);
    check("cats_full_intr", {7'd0, bus.intr}, 8'h01);
    rd();
    check("cats_rd0", bus.wordOut, 8'h63);
    check("cats_intr_after_rd0", {7'd0, bus.intr}, 8'h00);
    rd(); check("cats_rd1", bus.wordOut, 8'h61);
    rd(); check("cats_rd2", bus.wordOut, 8'h74);
    rd(); check("cats_rd3", bus.wordOut, 8'h73);
    check("cats_drained_intr", {7'd0, bus.intr}, 8'h00);

    wr(8'h62); wr(8'h69); wr(8'h72); wr(8'h64);
    check("bird_full_intr", {7'd0, bus.intr}, 8'h01);
    wr(8'h73);
    check("overflow_intr", {7'd0, bus.intr}, 8'h01);
    check("overflow_wordOut", bus.wordOut, 8'h73);

    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, i[0], 8'hA0 + 8'(i));
      check("gated_wordOut", bus.wordOut, 8'h73);
      check("gated_intr", {7'd0, bus.intr}, 8'h01);
    end

    rd(); check("bird_rd0", bus.wordOut, 8'h62);
    check("bird_intr_after_rd0", {7'd0, bus.intr}, 8'h00);
    rd(); check("bird_rd1", bus.wordOut, 8'h69);
    rd(); check("bird_rd2", bus.wordOut, 8'h72);
    rd(); check("bird_rd3", bus.wordOut, 8'h64);
    rd(); check("underflow_hold", bus.wordOut, 8'h64);
    check("underflow_intr", {7'd0, bus.intr}, 8'h00);

    wr(8'h11); wr(8'h22);
    step(1'b1, 1'b1, 1'b1, 8'h33);
    check("flush_wordOut", bus.wordOut, 8'h00);
    check("flush_intr", {7'd0, bus.intr}, 8'h00);
    rd();
    check("post_flush_read_ignored", bus.wordOut, 8'h00);
    wr(8'h44);
    rd();
    check("post_flush_new_word", bus.wordOut, 8'h44);
    rd();
    check("post_flush_underflow", bus.wordOut, 8'h44);

    wr(8'h01); wr(8'h02); wr(8'h03); wr(8'h04);
    check("refill_intr", {7'd0, bus.intr}, 8'h01);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    check("flush_full_intr", {7'd0, bus.intr}, 8'h00);
    wr(8'h55);
    check("one_word_intr", {7'd0, bus.intr}, 8'h00);
    rd();
    check("flush_full_new_word", bus.wordOut, 8'h55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
